// File: rtl/fifo_stream_buf_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fifo_stream_buf_pkg
// Description : Shared definitions for the stream FIFO: default widths,
//               output skid-stage state encoding and an occupancy helper.
// Revision    : 1.0 - initial release
// ============================================================================
package fifo_stream_buf_pkg;

    localparam int c_def_data_width = 32;
    localparam int c_def_addr_width = 4;

    // Output skid stage: number of valid words held in out0/out1.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } skid_state_t;

    function automatic logic [1:0] skid_count(input skid_state_t s);
        case (s)
            ONE:     return 2'd1;
            TWO:     return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_stream_buf_sync_dpram.sv
`default_nettype none
// ============================================================================
// Module      : sync_dpram
// Description : DATA_WIDTH x 2**ADDR_WIDTH storage, one synchronous write
//               port and one read port whose data is registered on re.
//               The array has no reset.
// Ports       : clk            - clock
//               we/waddr/wdata - write port
//               re/raddr       - read request, address
//               rdata          - read data, valid the cycle after re
// Revision    : 1.0 - initial release
// ============================================================================
module sync_dpram #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    localparam int c_depth = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] r_mem [c_depth];
    logic [DATA_WIDTH-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
        if (re) begin
            r_rdata <= r_mem[raddr];
        end
    end

    assign rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/fifo_stream_buf.sv
`default_nettype none
// ============================================================================
// Module      : fifo_stream_buf
// Description : Synchronous valid/ready stream FIFO. Words are stored in a
//               registered-read RAM; a 2-entry output skid stage hides the
//               read latency so one word per cycle flows in and out.
// Ports       : clk, rst                   - clock, sync active-high reset
//               wr_valid/wr_ready/wr_data  - input stream
//               rd_valid/rd_ready/rd_data  - output stream (rd_data = out0)
//               count                      - RAM + in-flight + skid words
//               full                       - RAM section holds DEPTH words
//               empty                      - count == 0
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_stream_buf
    import fifo_stream_buf_pkg::*;
#(
    parameter int DATA_WIDTH = c_def_data_width,
    parameter int ADDR_WIDTH = c_def_addr_width
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  full,
    output logic                  empty
);

    localparam int               c_ptr_w = ADDR_WIDTH + 1;
    localparam logic [c_ptr_w-1:0] c_depth = {1'b1, {ADDR_WIDTH{1'b0}}};

    // Registered state
    logic [c_ptr_w-1:0]    r_wptr;
    logic [c_ptr_w-1:0]    r_rptr;
    logic                  r_pending;   // RAM read issued last edge, data on rdata now
    logic                  r_full;
    skid_state_t           r_state;
    logic [DATA_WIDTH-1:0] r_out0;
    logic [DATA_WIDTH-1:0] r_out1;
    logic [c_ptr_w-1:0]    r_count;

    // Combinational
    logic [c_ptr_w-1:0]    w_occ;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_issue;
    logic [2:0]            w_committed;
    logic [DATA_WIDTH-1:0] w_ram_rdata;
    skid_state_t           w_state_next;
    logic [DATA_WIDTH-1:0] w_out0_next;
    logic [DATA_WIDTH-1:0] w_out1_next;
    logic [c_ptr_w-1:0]    w_wptr_next;
    logic [c_ptr_w-1:0]    w_rptr_next;
    logic [c_ptr_w-1:0]    w_occ_next;
    logic [c_ptr_w-1:0]    w_count_next;

    assign w_occ    = r_wptr - r_rptr;
    assign wr_ready = !r_full && !rst;
    assign rd_valid = (r_state != EMPTY);
    assign rd_data  = r_out0;
    assign count    = r_count;
    assign full     = r_full;
    assign empty    = (r_count == '0);

    assign w_push = wr_valid && wr_ready;
    assign w_pop  = rd_valid && rd_ready;

    // Words the skid stage will have to hold after this edge, counting the
    // read in flight. A new read may only issue if that leaves room for it.
    assign w_committed = {1'b0, skid_count(r_state)} + {2'b00, r_pending}
                       - {2'b00, w_pop};
    assign w_issue     = (w_occ != '0) && (w_committed < 3'd2);

    sync_dpram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk   (clk),
        .we    (w_push),
        .waddr (r_wptr[ADDR_WIDTH-1:0]),
        .wdata (wr_data),
        .re    (w_issue),
        .raddr (r_rptr[ADDR_WIDTH-1:0]),
        .rdata (w_ram_rdata)
    );

    // Skid stage next state. Landing data (r_pending) goes to out0 when out0
    // is free after this edge's pop, otherwise to out1.
    always_comb begin
        w_state_next = r_state;
        w_out0_next  = r_out0;
        w_out1_next  = r_out1;
        case (r_state)
            EMPTY: begin
                if (r_pending) begin
                    w_state_next = ONE;
                    w_out0_next  = w_ram_rdata;
                end
            end
            ONE: begin
                case ({r_pending, w_pop})
                    2'b10: begin
                        w_state_next = TWO;
                        w_out1_next  = w_ram_rdata;
                    end
                    2'b11: begin
                        w_out0_next  = w_ram_rdata;
                    end
                    2'b01: begin
                        w_state_next = EMPTY;
                    end
                    default: ;
                endcase
            end
            TWO: begin
                if (w_pop) begin
                    w_out0_next = r_out1;
                    if (r_pending) begin
                        w_out1_next  = w_ram_rdata;
                    end else begin
                        w_state_next = ONE;
                    end
                end
            end
            default: begin
                w_state_next = EMPTY;
            end
        endcase
    end

    assign w_wptr_next  = r_wptr + {{ADDR_WIDTH{1'b0}}, w_push};
    assign w_rptr_next  = r_rptr + {{ADDR_WIDTH{1'b0}}, w_issue};
    assign w_occ_next   = w_wptr_next - w_rptr_next;
    assign w_count_next = w_occ_next
                        + {{ADDR_WIDTH{1'b0}}, w_issue}
                        + {{(c_ptr_w-2){1'b0}}, skid_count(w_state_next)};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_pending <= 1'b0;
            r_full    <= 1'b0;
            r_state   <= EMPTY;
            r_out0    <= '0;
            r_out1    <= '0;
            r_count   <= '0;
        end else begin
            r_wptr    <= w_wptr_next;
            r_rptr    <= w_rptr_next;
            r_pending <= w_issue;
            r_full    <= (w_occ_next == c_depth);
            r_state   <= w_state_next;
            r_out0    <= w_out0_next;
            r_out1    <= w_out1_next;
            r_count   <= w_count_next;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fifo_stream_buf.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_stream_buf
// Description : Self-checking bench for fifo_stream_buf (DEPTH = 16).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_stream_buf;

    localparam int DW = 32;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wr_valid = 1'b0;
    logic          wr_ready;
    logic [DW-1:0] wr_data = '0;
    logic          rd_valid;
    logic          rd_ready = 1'b0;
    logic [DW-1:0] rd_data;
    logic [AW:0]   count;
    logic          full;
    logic          empty;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    logic [DW-1:0] sb_q[$];

    always #5 clk = ~clk;

    fifo_stream_buf #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .wr_data  (wr_data),
        .rd_valid (rd_valid),
        .rd_ready (rd_ready),
        .rd_data  (rd_data),
        .count    (count),
        .full     (full),
        .empty    (empty)
    );

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        n_checks++;
        if (wr_ready !== 1'b0) begin n_fail++; $display("FAIL reset_wr_ready_in_rst: got %0b want 0", wr_ready); end
        rst = 1'b0;
        step();
        n_checks++;
        if (count !== 5'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", count); end
        n_checks++;
        if (empty !== 1'b1 || full !== 1'b0) begin n_fail++; $display("FAIL reset_flags: empty=%0b full=%0b want 1/0", empty, full); end
        n_checks++;
        if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL reset_wr_ready: got %0b want 1", wr_ready); end
        n_checks++;
        if (rd_valid !== 1'b0 || rd_data !== '0) begin n_fail++; $display("FAIL reset_rd: valid=%0b data=%h want 0/0", rd_valid, rd_data); end
    endtask

    task automatic test_single();
        rd_ready = 1'b0;
        wr_valid = 1'b1;
        wr_data  = 32'hA5A5_0001;
        step();                 // edge N
        wr_valid = 1'b0;
        n_checks++;
        if (rd_valid !== 1'b0 || count !== 5'd1) begin n_fail++; $display("FAIL single_n: valid=%0b count=%0d want 0/1", rd_valid, count); end
        step();                 // edge N+1
        n_checks++;
        if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL single_n1: valid=%0b want 0", rd_valid); end
        step();                 // edge N+2
        n_checks++;
        if (rd_valid !== 1'b1 || rd_data !== 32'hA5A5_0001 || count !== 5'd1) begin
            n_fail++; $display("FAIL single_n2: valid=%0b data=%h count=%0d want 1/a5a50001/1", rd_valid, rd_data, count);
        end
        rd_ready = 1'b1;
        step();
        rd_ready = 1'b0;
        n_checks++;
        if (rd_valid !== 1'b0 || empty !== 1'b1) begin n_fail++; $display("FAIL single_drain: valid=%0b empty=%0b want 0/1", rd_valid, empty); end
    endtask

    task automatic test_fill();
        int guard;
        logic [DW-1:0] exp;
        rd_ready = 1'b0;
        for (int i = 0; i < 18; i++) begin
            wr_valid = 1'b1;
            wr_data  = DW'(i);
            n_checks++;
            if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL fill_accept_%0d: wr_ready=%0b want 1", i, wr_ready); end
            sb_q.push_back(DW'(i));
            step();
        end
        wr_data = 32'h0000_0099;
        n_checks++;
        if (full !== 1'b1 || wr_ready !== 1'b0 || count !== 5'd18) begin
            n_fail++; $display("FAIL fill_full: full=%0b wr_ready=%0b count=%0d want 1/0/18", full, wr_ready, count);
        end
        step();
        wr_valid = 1'b0;
        n_checks++;
        if (count !== 5'd18) begin n_fail++; $display("FAIL fill_19th_rejected: count=%0d want 18", count); end
        guard = 0;
        rd_ready = 1'b1;
        while (sb_q.size() != 0 && guard < 100) begin
            if (rd_valid) begin
                exp = sb_q.pop_front();
                n_checks++;
                if (rd_data !== exp) begin n_fail++; $display("FAIL fill_drain: got %h want %h", rd_data, exp); end
            end
            step();
            guard++;
        end
        rd_ready = 1'b0;
        n_checks++;
        if (guard >= 100) begin n_fail++; $display("FAIL fill_drain_timeout: %0d words left want 0", sb_q.size()); sb_q.delete(); end
        n_checks++;
        if (rd_valid !== 1'b0 || empty !== 1'b1) begin n_fail++; $display("FAIL fill_after_drain: valid=%0b empty=%0b want 0/1", rd_valid, empty); end
    endtask

    // Drives traffic, pushing expected words to the scoreboard on accept and
    // comparing on every pop; also checks output stability under stall.
    task automatic run_traffic(input int n_words, input bit random_bp,
                               output int first_pop, output int last_pop);
        int sent = 0;
        int got = 0;
        int guard = 0;
        bit hold_chk = 1'b0;
        logic [DW-1:0] held = '0;
        logic [DW-1:0] exp;
        first_pop = -1;
        last_pop  = -1;
        while (got < n_words && guard < 5000) begin
            if (hold_chk) begin
                n_checks++;
                if (rd_valid !== 1'b1 || rd_data !== held) begin
                    n_fail++; $display("FAIL hold: valid=%0b data=%h want 1/%h", rd_valid, rd_data, held);
                end
            end
            rd_ready = random_bp ? ($urandom_range(0, 2) != 0) : 1'b1;
            wr_valid = (sent < n_words) && (random_bp ? ($urandom_range(0, 3) != 0) : 1'b1);
            wr_data  = random_bp ? DW'($urandom) : DW'(sent);
            if (rd_valid && rd_ready) begin
                n_checks++;
                if (sb_q.size() == 0) begin
                    n_fail++; $display("FAIL traffic_extra: got %h want none", rd_data);
                end else begin
                    exp = sb_q.pop_front();
                    if (rd_data !== exp) begin n_fail++; $display("FAIL traffic_data: got %h want %h", rd_data, exp); end
                end
                got++;
                if (first_pop < 0) first_pop = cyc;
                last_pop = cyc;
            end
            hold_chk = rd_valid && !rd_ready;
            held     = rd_data;
            if (wr_valid && wr_ready) begin
                sb_q.push_back(wr_data);
                sent++;
            end
            step();
            guard++;
        end
        wr_valid = 1'b0;
        rd_ready = 1'b0;
        n_checks++;
        if (guard >= 5000) begin n_fail++; $display("FAIL traffic_timeout: got %0d words want %0d", got, n_words); end
        n_checks++;
        if (sb_q.size() != 0 || empty !== 1'b1 || rd_valid !== 1'b0) begin
            n_fail++; $display("FAIL traffic_end: left=%0d empty=%0b valid=%0b want 0/1/0", sb_q.size(), empty, rd_valid);
        end
        sb_q.delete();
    endtask

    task automatic test_stream();
        int f, l;
        run_traffic(40, 1'b0, f, l);
        n_checks++;
        if (l - f != 39) begin n_fail++; $display("FAIL stream_rate: span=%0d cycles want 39", l - f); end
    endtask

    task automatic test_backpressure();
        int f, l;
        run_traffic(200, 1'b1, f, l);
    endtask

    task automatic test_flush();
        int pops = 0;
        logic [DW-1:0] exp;
        rd_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            wr_valid = 1'b1;
            wr_data  = 32'hDEAD_0000 + DW'(i);
            step();
        end
        wr_valid = 1'b0;
        n_checks++;
        if (count !== 5'd10) begin n_fail++; $display("FAIL flush_pre_count: got %0d want 10", count); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_checks++;
        if (count !== 5'd0 || rd_valid !== 1'b0 || empty !== 1'b1 || rd_data !== '0) begin
            n_fail++; $display("FAIL flush_state: count=%0d valid=%0b empty=%0b data=%h want 0/0/1/0", count, rd_valid, empty, rd_data);
        end
        wr_valid = 1'b1;
        wr_data  = 32'h0000_1234;
        sb_q.push_back(32'h0000_1234);
        step();
        wr_valid = 1'b0;
        rd_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (rd_valid) begin
                pops++;
                n_checks++;
                if (sb_q.size() == 0) begin
                    n_fail++; $display("FAIL flush_stale: got %h want none", rd_data);
                end else begin
                    exp = sb_q.pop_front();
                    if (rd_data !== exp) begin n_fail++; $display("FAIL flush_word: got %h want %h", rd_data, exp); end
                end
            end
            step();
        end
        rd_ready = 1'b0;
        n_checks++;
        if (pops != 1) begin n_fail++; $display("FAIL flush_pop_count: got %0d want 1", pops); end
        sb_q.delete();
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_stream();
        test_backpressure();
        test_flush();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
